// File: rtl/fir_out_packer.sv
// fir_out_packer: output stage of the FIR datapath.
// Each complex partial sum from the last MAC is rounded (half-up), arithmetically
// right-shifted and saturated in one register stage, then queued in a small
// circular FIFO that feeds a valid/ready port. The MAC chain cannot be stalled,
// so samples arriving while the FIFO is full are dropped and flagged.
module fir_out_packer #(
  parameter int IN_W    = 32,
  parameter int OUT_W   = 16,
  parameter int DEPTH   = 8,
  parameter int SHIFT_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [2*IN_W-1:0]        in_data,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*OUT_W-1:0]       out_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     sat_flag
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Scale one component; result is {saturated, value}.
  function automatic logic [OUT_W:0] scale_comp(input logic [IN_W-1:0]    x,
                                                input logic [SHIFT_W-1:0] sh_in);
    logic signed [IN_W:0] ext;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] sum;
    logic signed [IN_W:0] shd;
    logic signed [IN_W:0] max_v;
    logic signed [IN_W:0] min_v;
    logic [OUT_W:0]       res;
    int                   sh;
    sh    = (int'(sh_in) > IN_W - 1) ? (IN_W - 1) : int'(sh_in);
    ext   = {x[IN_W-1], x};
    rnd   = (sh > 0) ? ({{IN_W{1'b0}}, 1'b1} << (sh - 1)) : '0;
    sum   = ext + rnd;
    shd   = sum >>> sh;
    max_v = {{(IN_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
    min_v = {{(IN_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};
    if (shd > max_v) begin
      res = {1'b1, 1'b0, {(OUT_W-1){1'b1}}};
    end else if (shd < min_v) begin
      res = {1'b1, 1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      res = {1'b0, shd[OUT_W-1:0]};
    end
    return res;
  endfunction

  logic                 s_valid_q;
  logic [2*OUT_W-1:0]   s_data_q;
  logic [2*OUT_W-1:0]   mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q;
  logic [PW-1:0]        rd_ptr_q;
  logic [CW-1:0]        count_q;
  logic                 overflow_q;
  logic                 sat_q;

  logic [OUT_W:0]       re_d;
  logic [OUT_W:0]       im_d;
  logic                 pop_d;
  logic                 push_d;
  logic                 drop_d;

  assign re_d   = scale_comp(in_data[2*IN_W-1:IN_W], shift);
  assign im_d   = scale_comp(in_data[IN_W-1:0], shift);

  // clear overrides both FIFO ports in its cycle.
  assign pop_d  = out_valid && out_ready && !clear;
  assign push_d = s_valid_q && !clear && ((count_q < CW'(DEPTH)) || pop_d);
  assign drop_d = s_valid_q && !clear && !push_d;

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign sat_flag  = sat_q;

  // Scale stage register and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
      sat_q     <= 1'b0;
    end else if (clear) begin
      s_valid_q <= 1'b0;
      sat_q     <= 1'b0;
    end else begin
      s_valid_q <= in_valid;
      if (in_valid) begin
        s_data_q <= {re_d[OUT_W-1:0], im_d[OUT_W-1:0]};
        if (re_d[OUT_W] || im_d[OUT_W]) begin
          sat_q <= 1'b1;
        end
      end
    end
  end

  // FIFO storage; contents beyond count are never observed, so no reset.
  always_ff @(posedge clk) begin
    if (push_d) begin
      mem_q[wr_ptr_q] <= s_data_q;
    end
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_d) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (pop_d) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      if (drop_d) begin
        overflow_q <= 1'b1;
      end
      case ({push_d, pop_d})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_out_packer.sv
// Bench for fir_out_packer: directed test-plan steps plus a random phase, all
// checked every cycle against a queue-based reference model.
module tb_fir_out_packer;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [63:0] in_data;
  logic [4:0]  shift;
  logic        clear;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [3:0]  count;
  logic        overflow;
  logic        sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  logic [31:0] mq[$];
  bit          m_sv;
  logic [31:0] m_sd;
  bit          m_ovf;
  bit          m_sat;

  fir_out_packer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .shift(shift), .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .count(count), .overflow(overflow), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // round half-up, floor-shift, saturate using plain integer arithmetic
  function automatic void mscale(input logic [31:0] raw, input int shv,
                                 output logic [15:0] y, output bit s);
    longint x;
    int     sh;
    x  = longint'($signed(raw));
    sh = (shv > 31) ? 31 : shv;
    if (sh > 0) x = x + (longint'(1) <<< (sh - 1));
    x = x >>> sh;
    s = 1'b0;
    if (x > 32767) begin
      y = 16'h7FFF; s = 1'b1;
    end else if (x < -32768) begin
      y = 16'h8000; s = 1'b1;
    end else begin
      y = x[15:0];
    end
  endfunction

  task automatic model_reset();
    mq.delete();
    m_sv  = 1'b0;
    m_sd  = '0;
    m_ovf = 1'b0;
    m_sat = 1'b0;
  endtask

  task automatic model_edge();
    bit          pop, push, s1, s2;
    logic [15:0] yr, yi;
    if (clear) begin
      mq.delete();
      m_sv  = 1'b0;
      m_ovf = 1'b0;
      m_sat = 1'b0;
    end else begin
      pop  = (mq.size() != 0) && out_ready;
      push = m_sv && ((mq.size() < DEPTH) || pop);
      if (m_sv && !push) m_ovf = 1'b1;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(m_sd);
      m_sv = in_valid;
      if (in_valid) begin
        mscale(in_data[63:32], int'(shift), yr, s1);
        mscale(in_data[31:0], int'(shift), yi, s2);
        m_sd = {yr, yi};
        if (s1 || s2) m_sat = 1'b1;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, (mq.size() != 0));
    chk("count", count, mq.size());
    chk("out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
    chk("overflow", overflow, m_ovf);
    chk("sat_flag", sat_flag, m_sat);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input bit v, input int re, input int im, input int sh);
    in_valid = v;
    in_data  = {re[31:0], im[31:0]};
    shift    = sh[4:0];
  endtask

  task automatic idle();
    drive(1'b0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; shift = '0;
    clear = 1'b0; out_ready = 1'b1;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    tick(); tick();

    // 1. rounding, 2-cycle latency
    drive(1'b1, 24, -24, 4);
    tick();
    idle();
    tick();
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 32'h0002FFFF);
    chk("t1_count", count, 4'd1);
    chk("t1_sat", sat_flag, 1'b0);
    tick();

    // 2. saturation
    drive(1'b1, 65536, -70000, 0);
    tick();
    chk("t2_sat_n1", sat_flag, 1'b1);
    drive(1'b1, 5, -5, 0);
    tick();
    chk("t2_data_sat", out_data, 32'h7FFF8000);
    idle();
    tick();
    chk("t2_data_small", out_data, 32'h0005FFFB);
    chk("t2_sat_sticky", sat_flag, 1'b1);
    tick();

    // 3. overflow then ordered drain
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive(1'b1, i, -i, 0);
      tick();
    end
    idle();
    tick(); tick();
    chk("t3_count", count, 4'd8);
    chk("t3_ovf", overflow, 1'b1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk("t3_drain_valid", out_valid, 1'b1);
      chk("t3_drain_data", out_data, {16'(i), 16'(-i)});
      tick();
    end
    chk("t3_empty", out_valid, 1'b0);

    // 4. full with simultaneous push/pop across pointer wraps
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, int'($urandom), int'($urandom), int'($urandom_range(0, 31)));
      tick();
    end
    idle();
    tick(); tick();
    chk("t4_full", count, 4'd8);
    drive(1'b1, int'($urandom), int'($urandom), int'($urandom_range(0, 31)));
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      drive(1'b1, int'($urandom), int'($urandom), int'($urandom_range(0, 31)));
      tick();
      chk("t4_count_hold", count, 4'd8);
      chk("t4_no_ovf", overflow, 1'b0);
    end
    idle();

    // 5. clear beats in_valid and pop
    clear = 1'b1; tick(); clear = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'h7FFFFFFF, 0, 0);
    tick();
    for (int i = 1; i < 9; i++) begin
      drive(1'b1, i * 100, i, 2);
      tick();
    end
    idle();
    tick(); tick();
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
    chk("t5_count5", count, 4'd5);
    chk("t5_ovf1", overflow, 1'b1);
    out_ready = 1'b1;
    clear = 1'b1;
    drive(1'b1, 7, 7, 0);
    tick();
    clear = 1'b0;
    idle();
    chk("t5_count0", count, 4'd0);
    chk("t5_valid0", out_valid, 1'b0);
    chk("t5_ovf0", overflow, 1'b0);
    chk("t5_sat0", sat_flag, 1'b0);
    tick(); tick();
    chk("t5_no_sample", out_valid, 1'b0);

    // 6. asynchronous reset mid-cycle
    out_ready = 1'b0;
    drive(1'b1, -32'sd2147483647, 1, 0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, i, i, 0);
      tick();
    end
    idle();
    tick(); tick();
    chk("t6_count5", count, 4'd5);
    chk("t6_sat1", sat_flag, 1'b1);
    @(posedge clk);
    model_edge();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_count", count, 4'd0);
    chk("t6_rst_sat", sat_flag, 1'b0);
    chk("t6_rst_ovf", overflow, 1'b0);
    chk("t6_rst_data", out_data, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 48, -40, 3);
    tick();
    idle();
    chk("t6_lat1", out_valid, 1'b0);
    tick();
    chk("t6_lat2_valid", out_valid, 1'b1);
    chk("t6_lat2_data", out_data, 32'h0006FFFB);
    tick();

    // random phase
    for (int i = 0; i < 400; i++) begin
      clear     = ($urandom_range(0, 39) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      drive(($urandom_range(0, 3) != 0), int'($urandom), int'($urandom),
            int'($urandom_range(0, 31)));
      if ($urandom_range(0, 1) == 0) in_data = {16'(int'($urandom_range(0, 65535)) - 32768) , 16'h0, 32'(int'($urandom_range(0, 20000000)) - 10000000)};
      tick();
    end
    clear = 1'b0;
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_out_packer.md
# fir_out_packer

Output stage of the FIR datapath. It consumes the final `{add_done, par_out}` stream of the last MAC in the tap chain. It rescales each complex partial sum (round, arithmetic right shift, saturate), buffers results in a small FIFO, and presents them on a valid/ready port to the host side. The MAC chain has no backpressure, so this block is the only point where stalls are absorbed; any loss is flagged.

## Interface
- `IN_W`, 32, width of each real/imag component of the incoming sample
- `OUT_W`, 16, width of each real/imag component of the output sample
- `DEPTH`, 8, FIFO entries; power of two, ≥2
- `SHIFT_W`, 5, width of the shift control

- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sample strobe; driven by MAC `add_done`
- `in_data`  in  2*IN_W  `{re, im}`, two's complement; driven by MAC `par_out`
- `shift`  in  SHIFT_W  right-shift amount, sampled with `in_valid`
- `clear`  in  1  synchronous flush of stage, FIFO and flags
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head this cycle
- `out_data`  out  2*OUT_W  `{re, im}` FIFO head
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy
- `overflow`  out  1  sticky; a sample was dropped
- `sat_flag`  out  1  sticky; a component saturated

## Operation
- **Scale stage**, one register stage with `s_valid` and `s_data`. Applied per component:
  - Clamp: `sh = min(shift, IN_W-1)`.
  - Extend `x` to IN_W+1 bits.
  - Round: if `sh > 0`, add `2^(sh-1)`. This is round-half-up, so -1.5 → -1.
  - Shift: arithmetic right shift by `sh`.
  - Saturate to `[-2^(OUT_W-1), 2^(OUT_W-1)-1]`. Any clipped component sets `sat_flag` on the same edge `s_valid` is loaded.
- **FIFO**, circular buffer of DEPTH entries with `wr_ptr`/`rd_ptr` wrapping modulo DEPTH and a separate `count`.
  - `push = s_valid && (count < DEPTH || pop)`.
  - `pop = out_valid && out_ready`.
  - `s_valid && !push` drops the sample and sets `overflow`.
  - Push and pop in the same cycle leave `count` unchanged. This also holds when full: the write succeeds and order is preserved.
- `out_valid = (count != 0)`; `out_data` = entry at `rd_ptr`.
- **Clear**, synchronous:
  - Empties FIFO (`count`=0, pointers=0), clears `s_valid`, `overflow` and `sat_flag`.
  - `clear` beats `in_valid` in the same cycle; that input is discarded without setting `overflow`.
  - `pop` in that cycle is ignored.
- **Reset** (`rst_n` low, asynchronous): `s_valid`=0, pointers=0, `count`=0, `out_valid`=0, `out_data`=0, `overflow`=0, `sat_flag`=0. Mid-operation reset discards all buffered samples immediately.
- Flags stay high until `clear` or reset.

## Timing
- `in_valid` at cycle N loads the scale stage at the end of N.
- Push at the end of N+1.
- With FIFO empty, `out_valid`/`out_data` are visible in N+2. Latency is 2 cycles.
- Throughput: 1 sample/cycle sustained while `out_ready`=1.
- `out_data` is stable while `out_valid`=1 and `out_ready`=0.
- `count` updates on the edge after push/pop.
- `sat_flag` rises in N+1; `overflow` rises the cycle after the failed push.
- Back-to-back `in_valid` is legal every cycle; no input gap is required.

## Test plan
1. **Rounding.** IN_W=32, OUT_W=16, `shift`=4, `in_data={24, -24}`, `out_ready`=1.
   - `out_valid` exactly 2 cycles later with `out_data={2, -1}`.
   - `sat_flag`=0 and `count` peaks at 1.
2. **Saturation.** `shift`=0, `{65536, -70000}`.
   - `out_data={0x7FFF, 0x8000}` and `sat_flag`=1 from N+1.
   - A following `{5,-5}` outputs `{5,-5}`; `sat_flag` stays 1.
3. **Overflow.** `out_ready`=0, 10 consecutive samples with values 1..10.
   - `count`=8 and `overflow`=1; samples 9 and 10 are lost.
   - Raising `out_ready` then drains 1..8 in order, one per cycle, and `out_valid` drops after 8.
4. **Full with simultaneous push/pop.** FIFO full and `out_ready`=1 with continuous input.
   - `count` holds at 8 and `overflow` stays 0.
   - Output order matches input order across several pointer wraps.
5. **Clear priority.** `count`=5, `overflow`=1, then `clear` and `in_valid` in the same cycle.
   - Next cycle: `count`=0, `out_valid`=0, `overflow`=0, `sat_flag`=0.
   - No sample appears two cycles later.
6. **Async reset.** `count`=5; pull `rst_n` low mid-cycle, away from the clock edge.
   - `out_valid`, `count` and the flags drop to 0 without waiting for a clock edge.
   - After release, a new sample emerges with 2-cycle latency.
